// File: rtl/udma_i2c_mc_pkg.sv
// Shared register map, status bit positions and per-channel config record for the multi-channel I2C register block.
// Declarations only; no latency and no backpressure apply.
package udma_i2c_mc_pkg;

    localparam logic [4:0] REG_RX_SADDR = 5'h00;
    localparam logic [4:0] REG_RX_SIZE  = 5'h01;
    localparam logic [4:0] REG_RX_CFG   = 5'h02;
    localparam logic [4:0] REG_TX_SADDR = 5'h03;
    localparam logic [4:0] REG_TX_SIZE  = 5'h04;
    localparam logic [4:0] REG_TX_CFG   = 5'h05;
    localparam logic [4:0] REG_STATUS   = 5'h06;
    localparam logic [4:0] REG_SETUP    = 5'h07;
    localparam logic [4:0] REG_IRQ_EN   = 5'h08;

    localparam int ST_BUSY = 0;
    localparam int ST_AL   = 1;
    localparam int ST_NACK = 2;

    // Fields are bus-wide; each channel exports only the low L2/TRANS bits.
    localparam int CFG_FIELD_W = 32;

    typedef struct packed {
        logic [CFG_FIELD_W-1:0] startaddr;
        logic [CFG_FIELD_W-1:0] size;
        logic                   continuous;
    } ch_cfg_t;

endpackage

// File: rtl/udma_i2c_mc_reg_if_if.sv
// uDMA cfg bus bundle: master drives the access, slave returns read data and ready.
// Read data is combinational in the access cycle; ready is always high, so there is no backpressure.
interface udma_i2c_mc_reg_if_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]       cfg_data_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic              cfg_valid_i;
    logic              cfg_rwn_i;
    logic [31:0]       cfg_data_o;
    logic              cfg_ready_o;

    modport master (output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
                    input  cfg_data_o, cfg_ready_o);
    modport slave  (input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
                    output cfg_data_o, cfg_ready_o);
endinterface

// File: rtl/udma_i2c_ch_regs.sv
// One channel's config, en/clr pulses, soft-reset counter, sticky status and IRQ.
// Writes take effect at the next edge and IRQ lags the sticky bits by one cycle; read data is combinational; there is no backpressure.
module udma_i2c_ch_regs #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int RST_CYCLES     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic                      rd_status_i,
    input  logic [4:0]                offset_i,
    input  logic [31:0]               wdata_i,
    output logic [31:0]               rdata_o,
    output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     rx_size_o,
    output logic                      rx_continuous_o,
    output logic                      rx_en_o,
    output logic                      rx_clr_o,
    input  logic                      rx_en_i,
    input  logic                      rx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     rx_bytes_left_i,
    output logic [L2_AWIDTH_NOAL-1:0] tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     tx_size_o,
    output logic                      tx_continuous_o,
    output logic                      tx_en_o,
    output logic                      tx_clr_o,
    input  logic                      tx_en_i,
    input  logic                      tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     tx_bytes_left_i,
    output logic                      do_rst_o,
    input  logic                      busy_i,
    input  logic                      al_i,
    input  logic                      nack_i,
    output logic                      irq_o
);
    import udma_i2c_mc_pkg::*;

    localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

    ch_cfg_t     rx_cfg_q, rx_cfg_d, tx_cfg_q, tx_cfg_d;
    logic        rx_en_q, rx_en_d, rx_clr_q, rx_clr_d;
    logic        tx_en_q, tx_en_d, tx_clr_q, tx_clr_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [2:0]  status_q, status_d;
    logic [2:0]  irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic        unused_cfg_bits;

    always_comb begin
        rx_cfg_d  = rx_cfg_q;
        tx_cfg_d  = tx_cfg_q;
        rx_en_d   = 1'b0;
        rx_clr_d  = 1'b0;
        tx_en_d   = 1'b0;
        tx_clr_d  = 1'b0;
        irq_en_d  = irq_en_q;
        rst_cnt_d = (rst_cnt_q != 8'd0) ? rst_cnt_q - 8'd1 : 8'd0;
        // Clearing read and a new event in the same cycle: the event wins.
        status_d           = rd_status_i ? 3'b000 : status_q;
        status_d[ST_BUSY]  = status_d[ST_BUSY] | busy_i;
        status_d[ST_AL]    = status_d[ST_AL]   | al_i;
        status_d[ST_NACK]  = status_d[ST_NACK] | nack_i;
        irq_d              = |(status_q & irq_en_q);
        if (wr_en_i) begin
            case (offset_i)
                REG_RX_SADDR: rx_cfg_d.startaddr = wdata_i;
                REG_RX_SIZE:  rx_cfg_d.size      = wdata_i;
                REG_RX_CFG: begin
                    rx_cfg_d.continuous = wdata_i[0];
                    rx_en_d             = wdata_i[4];
                    rx_clr_d            = wdata_i[5];
                end
                REG_TX_SADDR: tx_cfg_d.startaddr = wdata_i;
                REG_TX_SIZE:  tx_cfg_d.size      = wdata_i;
                REG_TX_CFG: begin
                    tx_cfg_d.continuous = wdata_i[0];
                    tx_en_d             = wdata_i[4];
                    tx_clr_d            = wdata_i[5];
                end
                REG_SETUP:    rst_cnt_d = wdata_i[0] ? RST_LOAD : 8'd0;
                REG_IRQ_EN:   irq_en_d  = wdata_i[2:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_cfg_q  <= '0;
            tx_cfg_q  <= '0;
            rx_en_q   <= 1'b0;
            rx_clr_q  <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_clr_q  <= 1'b0;
            rst_cnt_q <= 8'd0;
            status_q  <= 3'b000;
            irq_en_q  <= 3'b000;
            irq_q     <= 1'b0;
        end else begin
            rx_cfg_q  <= rx_cfg_d;
            tx_cfg_q  <= tx_cfg_d;
            rx_en_q   <= rx_en_d;
            rx_clr_q  <= rx_clr_d;
            tx_en_q   <= tx_en_d;
            tx_clr_q  <= tx_clr_d;
            rst_cnt_q <= rst_cnt_d;
            status_q  <= status_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (offset_i)
            REG_RX_SADDR: rdata_o = 32'(rx_curr_addr_i);
            REG_RX_SIZE:  rdata_o = 32'(rx_bytes_left_i);
            REG_RX_CFG:   rdata_o = {26'h0, rx_pending_i, rx_en_i, 3'h0, rx_cfg_q.continuous};
            REG_TX_SADDR: rdata_o = 32'(tx_curr_addr_i);
            REG_TX_SIZE:  rdata_o = 32'(tx_bytes_left_i);
            REG_TX_CFG:   rdata_o = {26'h0, tx_pending_i, tx_en_i, 3'h0, tx_cfg_q.continuous};
            REG_STATUS:   rdata_o = {29'h0, status_q};
            REG_SETUP:    rdata_o = {24'h0, rst_cnt_q};
            REG_IRQ_EN:   rdata_o = {29'h0, irq_en_q};
            default:      rdata_o = 32'h0;
        endcase
    end

    assign rx_startaddr_o  = rx_cfg_q.startaddr[L2_AWIDTH_NOAL-1:0];
    assign rx_size_o       = rx_cfg_q.size[TRANS_SIZE-1:0];
    assign rx_continuous_o = rx_cfg_q.continuous;
    assign rx_en_o         = rx_en_q;
    assign rx_clr_o        = rx_clr_q;
    assign tx_startaddr_o  = tx_cfg_q.startaddr[L2_AWIDTH_NOAL-1:0];
    assign tx_size_o       = tx_cfg_q.size[TRANS_SIZE-1:0];
    assign tx_continuous_o = tx_cfg_q.continuous;
    assign tx_en_o         = tx_en_q;
    assign tx_clr_o        = tx_clr_q;
    assign do_rst_o        = (rst_cnt_q != 8'd0);
    assign irq_o           = irq_q;
    assign unused_cfg_bits = ^{rx_cfg_q, tx_cfg_q};

endmodule

// File: rtl/udma_i2c_mc_reg_if.sv
// Multi-channel uDMA I2C register file: decodes channel/offset and muxes per-channel read data.
// Read data is combinational in the access cycle and ready is tied high, so there is no backpressure.
module udma_i2c_mc_reg_if #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int N_CH           = 2,
    parameter int RST_CYCLES     = 4,
    localparam int CH_AW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    udma_i2c_mc_reg_if_if.slave            cfg,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [N_CH-1:0]                cfg_tx_continuous_o,
    output logic [N_CH-1:0]                cfg_tx_en_o,
    output logic [N_CH-1:0]                cfg_tx_clr_o,
    input  logic [N_CH-1:0]                cfg_tx_en_i,
    input  logic [N_CH-1:0]                cfg_tx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
    output logic [N_CH-1:0]                cfg_do_rst_o,
    input  logic [N_CH-1:0]                status_busy_i,
    input  logic [N_CH-1:0]                status_al_i,
    input  logic [N_CH-1:0]                status_nack_i,
    output logic [N_CH-1:0]                irq_o
);
    import udma_i2c_mc_pkg::*;

    logic [CH_AW-1:0] ch_idx;
    logic [4:0]       offset;
    logic             wr_acc, rd_acc;
    // Sized to the full select space; slots >= N_CH read as zero.
    logic [31:0]      ch_rdata [2**CH_AW];

    assign ch_idx = cfg.cfg_addr_i[CH_AW+4:5];
    assign offset = cfg.cfg_addr_i[4:0];
    assign wr_acc = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
    assign rd_acc = cfg.cfg_valid_i &  cfg.cfg_rwn_i;

    for (genvar c = 0; c < 2**CH_AW; c++) begin : gen_ch
        if (c < N_CH) begin : gen_live
            logic sel;
            assign sel = (ch_idx == CH_AW'(c));

            udma_i2c_ch_regs #(
                .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
                .TRANS_SIZE     (TRANS_SIZE),
                .RST_CYCLES     (RST_CYCLES)
            ) u_ch (
                .clk_i           (clk_i),
                .rst_i           (rst_i),
                .wr_en_i         (wr_acc & sel),
                .rd_status_i     (rd_acc & sel & (offset == REG_STATUS)),
                .offset_i        (offset),
                .wdata_i         (cfg.cfg_data_i),
                .rdata_o         (ch_rdata[c]),
                .rx_startaddr_o  (cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
                .rx_size_o       (cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
                .rx_continuous_o (cfg_rx_continuous_o[c]),
                .rx_en_o         (cfg_rx_en_o[c]),
                .rx_clr_o        (cfg_rx_clr_o[c]),
                .rx_en_i         (cfg_rx_en_i[c]),
                .rx_pending_i    (cfg_rx_pending_i[c]),
                .rx_curr_addr_i  (cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
                .rx_bytes_left_i (cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
                .tx_startaddr_o  (cfg_tx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
                .tx_size_o       (cfg_tx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
                .tx_continuous_o (cfg_tx_continuous_o[c]),
                .tx_en_o         (cfg_tx_en_o[c]),
                .tx_clr_o        (cfg_tx_clr_o[c]),
                .tx_en_i         (cfg_tx_en_i[c]),
                .tx_pending_i    (cfg_tx_pending_i[c]),
                .tx_curr_addr_i  (cfg_tx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
                .tx_bytes_left_i (cfg_tx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
                .do_rst_o        (cfg_do_rst_o[c]),
                .busy_i          (status_busy_i[c]),
                .al_i            (status_al_i[c]),
                .nack_i          (status_nack_i[c]),
                .irq_o           (irq_o[c])
            );
        end else begin : gen_empty
            assign ch_rdata[c] = 32'h0;
        end
    end

    assign cfg.cfg_data_o  = rd_acc ? ch_rdata[ch_idx] : 32'h0;
    assign cfg.cfg_ready_o = 1'b1;

endmodule

// File: tb/tb_udma_i2c_mc_reg_if.sv
// Directed bench for udma_i2c_mc_reg_if with three channels so channel index 3 is out of range.
module tb_udma_i2c_mc_reg_if;
    localparam int AW  = 12;
    localparam int SW  = 16;
    localparam int NCH = 3;
    localparam int RC  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udma_i2c_mc_reg_if_if #(.ADDR_W(7)) cfg_bus ();

    logic [NCH*AW-1:0] rx_saddr, tx_saddr, rx_curr, tx_curr;
    logic [NCH*SW-1:0] rx_size, tx_size, rx_left, tx_left;
    logic [NCH-1:0]    rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr;
    logic [NCH-1:0]    rx_en_st, rx_pend, tx_en_st, tx_pend;
    logic [NCH-1:0]    do_rst, busy, al, nack, irq;

    udma_i2c_mc_reg_if #(
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (SW),
        .N_CH           (NCH),
        .RST_CYCLES     (RC)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cfg                 (cfg_bus),
        .cfg_rx_startaddr_o  (rx_saddr),
        .cfg_rx_size_o       (rx_size),
        .cfg_rx_continuous_o (rx_cont),
        .cfg_rx_en_o         (rx_en),
        .cfg_rx_clr_o        (rx_clr),
        .cfg_rx_en_i         (rx_en_st),
        .cfg_rx_pending_i    (rx_pend),
        .cfg_rx_curr_addr_i  (rx_curr),
        .cfg_rx_bytes_left_i (rx_left),
        .cfg_tx_startaddr_o  (tx_saddr),
        .cfg_tx_size_o       (tx_size),
        .cfg_tx_continuous_o (tx_cont),
        .cfg_tx_en_o         (tx_en),
        .cfg_tx_clr_o        (tx_clr),
        .cfg_tx_en_i         (tx_en_st),
        .cfg_tx_pending_i    (tx_pend),
        .cfg_tx_curr_addr_i  (tx_curr),
        .cfg_tx_bytes_left_i (tx_left),
        .cfg_do_rst_o        (do_rst),
        .status_busy_i       (busy),
        .status_al_i         (al),
        .status_nack_i       (nack),
        .irq_o               (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge; the access is taken at the rising edge in between.
    task automatic wr(input int ch, input int off, input logic [31:0] d);
        cfg_bus.cfg_addr_i  = 7'((ch << 5) | off);
        cfg_bus.cfg_data_i  = d;
        cfg_bus.cfg_rwn_i   = 1'b0;
        cfg_bus.cfg_valid_i = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid_i = 1'b0;
    endtask

    task automatic rd(input int ch, input int off, output logic [31:0] d);
        cfg_bus.cfg_addr_i  = 7'((ch << 5) | off);
        cfg_bus.cfg_rwn_i   = 1'b1;
        cfg_bus.cfg_valid_i = 1'b1;
        #1 d = cfg_bus.cfg_data_o;
        @(negedge clk);
        cfg_bus.cfg_valid_i = 1'b0;
    endtask

    logic [31:0] r;
    logic [NCH*SW-1:0] size_snap;
    int hi;

    initial begin
        rst = 1'b1;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i   = 1'b1;
        cfg_bus.cfg_addr_i  = '0;
        cfg_bus.cfg_data_i  = '0;
        {rx_curr, tx_curr, rx_left, tx_left} = '0;
        {rx_en_st, rx_pend, tx_en_st, tx_pend} = '0;
        {busy, al, nack} = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        for (int ch = 0; ch < 2; ch++)
            for (int off = 0; off <= 8; off++) begin
                rd(ch, off, r);
                chk($sformatf("rst_rd_c%0d_o%0d", ch, off), 64'(r), 64'h0);
            end
        chk("rst_pulses", 64'({rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr, do_rst, irq}), 64'h0);
        chk("rst_addr", 64'({rx_saddr, tx_saddr}), 64'h0);
        chk("rst_size", 64'({rx_size, tx_size}) | 64'h0, 64'h0);
        chk("ready", 64'(cfg_bus.cfg_ready_o), 64'h1);

        // Config and pulses
        wr(1, 0, 32'h123);
        chk("rx_saddr_c1", 64'(rx_saddr[AW +: AW]), 64'h123);
        chk("rx_saddr_c0", 64'(rx_saddr[0 +: AW]), 64'h0);
        wr(1, 2, 32'h31);
        chk("rx_en_pulse", 64'(rx_en), 64'b010);
        chk("rx_clr_pulse", 64'(rx_clr), 64'b010);
        chk("rx_cont", 64'(rx_cont), 64'b010);
        @(negedge clk);
        chk("rx_en_drop", 64'(rx_en), 64'h0);
        chk("rx_clr_drop", 64'(rx_clr), 64'h0);
        chk("rx_cont_hold", 64'(rx_cont), 64'b010);
        wr(1, 2, 32'h01);
        chk("no_pulse", 64'({rx_en, rx_clr}), 64'h0);
        chk("tx_untouched", 64'({tx_en, tx_clr, tx_cont}), 64'h0);
        rx_en_st = 3'b010; rx_pend = 3'b010;
        rx_curr[AW +: AW] = 12'hABC;
        rx_left[SW +: SW] = 16'h1234;
        rd(1, 2, r); chk("rx_cfg_rd", 64'(r), 64'h31);
        rd(1, 0, r); chk("rx_curr_rd", 64'(r), 64'hABC);
        rd(1, 1, r); chk("rx_left_rd", 64'(r), 64'h1234);
        rd(0, 2, r); chk("rx_cfg_rd_c0", 64'(r), 64'h0);
        wr(0, 4, 32'hBEEF);
        chk("tx_size_c0", 64'(tx_size[0 +: SW]), 64'hBEEF);
        wr(2, 3, 32'h7FF);
        chk("tx_saddr_c2", 64'(tx_saddr[2*AW +: AW]), 64'h7FF);

        // Soft reset: plain pulse
        hi = 0;
        wr(0, 7, 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (do_rst[0]) hi++;
            @(negedge clk);
        end
        chk("srst_len", 64'(hi), 64'd4);

        // Soft reset: reload during the second high cycle
        hi = 0;
        wr(0, 7, 32'h1);
        if (do_rst[0]) hi++;
        @(negedge clk);
        if (do_rst[0]) hi++;
        wr(0, 7, 32'h1);
        for (int i = 0; i < 10; i++) begin
            if (do_rst[0]) hi++;
            @(negedge clk);
        end
        chk("srst_ext_len", 64'(hi), 64'd6);

        // Soft reset: readback and abort
        wr(0, 7, 32'h1);
        chk("srst_hi", 64'(do_rst), 64'b001);
        rd(0, 7, r); chk("setup_rd", 64'(r), 64'd4);
        wr(0, 7, 32'h0);
        chk("srst_abort", 64'(do_rst), 64'h0);
        rd(0, 4, r);
        chk("srst_keeps_regs", 64'(tx_size[0 +: SW]), 64'hBEEF);

        // Sticky status and IRQ on channel 1
        wr(1, 8, 32'h2);
        al = 3'b010;
        @(negedge clk);
        al = 3'b000;
        chk("irq_lag", 64'(irq), 64'h0);
        @(negedge clk);
        chk("irq_rise", 64'(irq), 64'b010);
        rd(1, 6, r); chk("status_al", 64'(r), 64'h2);
        rd(1, 6, r); chk("status_clr", 64'(r), 64'h0);
        chk("irq_drop", 64'(irq), 64'h0);
        busy = 3'b010;
        @(negedge clk);
        busy = 3'b000;
        @(negedge clk);
        @(negedge clk);
        chk("irq_masked", 64'(irq), 64'h0);
        rd(1, 6, r); chk("status_busy", 64'(r), 64'h1);

        // Set wins over clearing read on channel 0
        al = 3'b001;
        @(negedge clk);
        al = 3'b000;
        nack = 3'b001;
        rd(0, 6, r); chk("setwin_old", 64'(r), 64'h2);
        nack = 3'b000;
        rd(0, 6, r); chk("setwin_new", 64'(r), 64'h4);
        rd(0, 6, r); chk("setwin_clr", 64'(r), 64'h0);
        chk("irq_c0_unmasked_off", 64'(irq), 64'h0);

        // Out-of-range channel and unmapped offset
        size_snap = rx_size;
        wr(3, 1, 32'hFFFF);
        chk("oor_wr", 64'(rx_size), 64'(size_snap));
        rd(3, 1, r); chk("oor_rd", 64'(r), 64'h0);
        rd(3, 8, r); chk("oor_rd_irqen", 64'(r), 64'h0);
        wr(0, 9, 32'hFFFF_FFFF);
        rd(0, 9, r); chk("unmapped_rd", 64'(r), 64'h0);
        rd(0, 8, r); chk("unmapped_no_alias", 64'(r), 64'h0);
        rd(2, 8, r); chk("c2_irqen", 64'(r), 64'h0);
        chk("ready_end", 64'(cfg_bus.cfg_ready_o), 64'h1);

        // Reset wins over a concurrent write
        rst = 1'b1;
        wr(0, 8, 32'h7);
        rst = 1'b0;
        rd(0, 8, r); chk("rst_prio", 64'(r), 64'h0);
        chk("rst_clears_saddr", 64'(rx_saddr[AW +: AW]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
